irrigation_tank_scheduler: RTL and testbench

Sequencer and arbiter for the shared water tank. It grants tank water to two irrigation requesters, sprinkler and drip. It drains the 3-bit tank consumption counter while water flows and drives the inlet valve to refill the tank. Its `water_level` output feeds the matrix column-bar decoder directly: 0 is full and all columns are lit, 7 is empty and no columns are lit.

---
 rtl/irrigation_tank_scheduler_if.sv | 40 ++++
 rtl/irrigation_tank_scheduler.sv | 165 ++++++++++++++++
 tb/tb_irrigation_tank_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/irrigation_tank_scheduler_if.sv
// Request / grant / tank-level bundle between the irrigation tank scheduler and its users.
// The master side drives the requests and the tick; the slave side is the scheduler.
interface irrigation_tank_scheduler_if;
    logic       tick;
    logic       req_sprinkler;
    logic       req_drip;
    logic       refill_req;
    logic       grant_sprinkler;
    logic       grant_drip;
    logic       inlet_valve;
    logic [2:0] water_level;
    logic       tank_empty;
    logic       tank_full;

    modport master (
        output tick,
        output req_sprinkler,
        output req_drip,
        output refill_req,
        input  grant_sprinkler,
        input  grant_drip,
        input  inlet_valve,
        input  water_level,
        input  tank_empty,
        input  tank_full
    );

    modport slave (
        input  tick,
        input  req_sprinkler,
        input  req_drip,
        input  refill_req,
        output grant_sprinkler,
        output grant_drip,
        output inlet_valve,
        output water_level,
        output tank_empty,
        output tank_full
    );
endinterface

// File: rtl/irrigation_tank_scheduler.sv
// Shared-tank sequencer: grants water to sprinkler or drip, tracks consumption, refills the tank.
// Optional macro IRRIGATION_ROUND_ROBIN_EN replaces fixed sprinkler priority with round-robin.
module irrigation_tank_scheduler #(
    parameter int SPRINKLER_TICKS = 4,
    parameter int DRIP_TICKS      = 8,
    parameter int REFILL_TICKS    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    irrigation_tank_scheduler_if.slave  tank
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPRINKLE,
        ST_DRIP,
        ST_REFILL
    } state_t;

    localparam logic [3:0] SPR_LAST    = 4'(SPRINKLER_TICKS - 1);
    localparam logic [3:0] DRIP_LAST   = 4'(DRIP_TICKS - 1);
    localparam logic [3:0] REFILL_LAST = 4'(REFILL_TICKS - 1);
    localparam logic [2:0] LEVEL_EMPTY = 3'd7;
    localparam logic [2:0] LEVEL_FULL  = 3'd0;

    state_t     state;
    state_t     state_next;
    logic [3:0] step;
    logic [3:0] step_next;
    logic [2:0] level;
    logic [2:0] level_next;
    logic       own_req;
    logic [3:0] step_last;
    logic       pick_drip;

    // ------------------------------------------------------------------
    // Arbitration between simultaneous requests in IDLE
    // ------------------------------------------------------------------
`ifdef IRRIGATION_ROUND_ROBIN_EN
    logic favour_drip;

    // Remember who was served last so the other side wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour_drip <= 1'b0;
        end else if (state == ST_IDLE && state_next == ST_SPRINKLE) begin
            favour_drip <= 1'b1;
        end else if (state == ST_IDLE && state_next == ST_DRIP) begin
            favour_drip <= 1'b0;
        end
    end

    assign pick_drip = tank.req_drip && (!tank.req_sprinkler || favour_drip);
`else
    assign pick_drip = tank.req_drip && !tank.req_sprinkler;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            step  <= '0;
            level <= LEVEL_FULL;
        end else begin
            state <= state_next;
            step  <= step_next;
            level <= level_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        step_next  = step;
        level_next = level;
        own_req    = 1'b0;
        step_last  = SPR_LAST;

        unique case (state)
            ST_IDLE: begin
                if (level == LEVEL_EMPTY) begin
                    state_next = ST_REFILL;
                end else if (tank.req_sprinkler || tank.req_drip) begin
                    state_next = pick_drip ? ST_DRIP : ST_SPRINKLE;
                end else if (tank.refill_req && level != LEVEL_FULL) begin
                    state_next = ST_REFILL;
                end
            end

            ST_SPRINKLE, ST_DRIP: begin
                own_req   = (state == ST_SPRINKLE) ? tank.req_sprinkler : tank.req_drip;
                step_last = (state == ST_SPRINKLE) ? SPR_LAST : DRIP_LAST;
                // A dropped request wins over a coincident tick; the partial count is lost.
                if (!own_req) begin
                    state_next = ST_IDLE;
                end else if (tank.tick) begin
                    if (step == step_last) begin
                        step_next = '0;
                        if (level != LEVEL_EMPTY) begin
                            level_next = level + 3'd1;
                        end
                        if (level >= LEVEL_EMPTY - 3'd1) begin
                            state_next = ST_REFILL;
                        end
                    end else begin
                        step_next = step + 4'd1;
                    end
                end
            end

            ST_REFILL: begin
                if (level == LEVEL_FULL) begin
                    state_next = ST_IDLE;
                end else if (tank.tick) begin
                    if (step == REFILL_LAST) begin
                        step_next  = '0;
                        level_next = level - 3'd1;
                        if (level == 3'd1) begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        step_next = step + 4'd1;
                    end
                end
            end
        endcase

        if (state_next != state) begin
            step_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode: purely from registered state and level
    // ------------------------------------------------------------------
    always_comb begin
        tank.grant_sprinkler = 1'b0;
        tank.grant_drip      = 1'b0;
        tank.inlet_valve     = 1'b0;

        unique case (state)
            ST_IDLE:     ;
            ST_SPRINKLE: tank.grant_sprinkler = 1'b1;
            ST_DRIP:     tank.grant_drip      = 1'b1;
            ST_REFILL:   tank.inlet_valve     = 1'b1;
        endcase

        tank.water_level = level;
        tank.tank_empty  = (level == LEVEL_EMPTY);
        tank.tank_full   = (level == LEVEL_FULL);
    end

    // Valves are mutually exclusive by construction of the state encoding.
    assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({tank.grant_sprinkler, tank.grant_drip, tank.inlet_valve}));

endmodule

// File: tb/tb_irrigation_tank_scheduler.sv
// Directed, table-driven bench for irrigation_tank_scheduler with default tick parameters.
// Expectations for tied requests follow IRRIGATION_ROUND_ROBIN_EN when the bench is built with it.
module tb_irrigation_tank_scheduler;

`ifdef IRRIGATION_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        string      name;
        bit         rs;
        bit         rd;
        bit         rf;
        bit         tk;
        int         cycles;
        bit         gs;
        bit         gd;
        bit         inl;
        logic [2:0] lvl;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;
    vec_t vecs[$];

    irrigation_tank_scheduler_if tank_if ();

    irrigation_tank_scheduler #(
        .SPRINKLER_TICKS (4),
        .DRIP_TICKS      (8),
        .REFILL_TICKS    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tank  (tank_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {grant_sprinkler, grant_drip, inlet_valve, tank_empty, tank_full, water_level}
    function automatic logic [7:0] pack_exp(input bit gs, input bit gd, input bit inl,
                                            input logic [2:0] lvl);
        return {gs, gd, inl, (lvl == 3'd7), (lvl == 3'd0), lvl};
    endfunction

    function automatic logic [7:0] pack_act();
        return {tank_if.grant_sprinkler, tank_if.grant_drip, tank_if.inlet_valve,
                tank_if.tank_empty, tank_if.tank_full, tank_if.water_level};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got gs/gd/inlet/empty/full/level=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input bit rs, input bit rd, input bit rf,
                           input bit tk, input int cycles, input bit gs, input bit gd,
                           input bit inl, input logic [2:0] lvl);
        vec_t v;
        v.name = name; v.rs = rs; v.rd = rd; v.rf = rf; v.tk = tk; v.cycles = cycles;
        v.gs = gs; v.gd = gd; v.inl = inl; v.lvl = lvl;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit rs, input bit rd, input bit rf, input bit tk);
        tank_if.req_sprinkler = rs;
        tank_if.req_drip      = rd;
        tank_if.refill_req    = rf;
        tank_if.tick          = tk;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        //       name            rs rd rf tk cyc  gs gd in lvl
        // Sprinkler drains the full tank, then refill brings it back.
        add_vec("spr_grant",     1, 0, 0, 1,  1,  1, 0, 0, 3'd0);
        add_vec("spr_3ticks",    1, 0, 0, 1,  3,  1, 0, 0, 3'd0);
        add_vec("spr_step1",     1, 0, 0, 1,  1,  1, 0, 0, 3'd1);
        add_vec("spr_lvl6",      1, 0, 0, 1, 23,  1, 0, 0, 3'd6);
        add_vec("spr_empty",     1, 0, 0, 1,  1,  0, 0, 1, 3'd7);
        add_vec("refill_13",     1, 0, 0, 1, 13,  0, 0, 1, 3'd1);
        add_vec("refill_done",   1, 0, 0, 1,  1,  0, 0, 0, 3'd0);
        add_vec("idle_tick",     0, 0, 0, 1,  2,  0, 0, 0, 3'd0);
        // Drip partial step is discarded on request drop.
        add_vec("drip_grant",    0, 1, 0, 1,  1,  0, 1, 0, 3'd0);
        add_vec("drip_12",       0, 1, 0, 1, 12,  0, 1, 0, 3'd1);
        add_vec("drip_drop",     0, 0, 0, 1,  1,  0, 0, 0, 3'd1);
        add_vec("drip_regrant",  0, 1, 0, 1,  1,  0, 1, 0, 3'd1);
        add_vec("drip_7",        0, 1, 0, 1,  7,  0, 1, 0, 3'd1);
        add_vec("drip_step",     0, 1, 0, 1,  1,  0, 1, 0, 3'd2);
        add_vec("drip_off",      0, 0, 0, 0,  1,  0, 0, 0, 3'd2);
        // Arbitration and no preemption, tick held low.
        add_vec("both_first",    1, 1, 0, 0,  1,  1, 0, 0, 3'd2);
        add_vec("spr_drop",      0, 1, 0, 0,  1,  0, 0, 0, 3'd2);
        add_vec("drip_next",     0, 1, 0, 0,  1,  0, 1, 0, 3'd2);
        add_vec("no_preempt",    1, 1, 0, 0,  2,  0, 1, 0, 3'd2);
        add_vec("drip_drop2",    1, 0, 0, 0,  1,  0, 0, 0, 3'd2);
        add_vec("spr_only",      1, 0, 0, 0,  1,  1, 0, 0, 3'd2);
        add_vec("idle_gap",      0, 0, 0, 0,  1,  0, 0, 0, 3'd2);
        add_vec("both_again",    1, 1, 0, 0,  1, !RR, RR, 0, 3'd2);
        add_vec("release",       0, 0, 0, 0,  1,  0, 0, 0, 3'd2);
        // Operator refill from level 3; requests ignored while refilling.
        add_vec("spr_to3",       1, 0, 0, 1,  5,  1, 0, 0, 3'd3);
        add_vec("spr_off",       0, 0, 0, 0,  1,  0, 0, 0, 3'd3);
        add_vec("refill_enter",  0, 0, 1, 1,  1,  0, 0, 1, 3'd3);
        add_vec("refill_5",      1, 0, 0, 1,  5,  0, 0, 1, 3'd1);
        add_vec("refill_zero",   1, 0, 0, 1,  1,  0, 0, 0, 3'd0);
        add_vec("spr_after",     1, 0, 0, 1,  1,  1, 0, 0, 3'd0);
        add_vec("spr_off2",      0, 0, 0, 0,  1,  0, 0, 0, 3'd0);
        // Refill request on a full tank is ignored.
        add_vec("refill_full",   0, 0, 1, 1,  2,  0, 0, 0, 3'd0);
        add_vec("refill_clr",    0, 0, 0, 0,  1,  0, 0, 0, 3'd0);
        // Drain to level 5 ahead of the asynchronous reset sequence.
        add_vec("spr_to5",       1, 0, 0, 1, 21,  1, 0, 0, 3'd5);

        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_state", pack_act(), pack_exp(0, 0, 0, 3'd0));

        foreach (vecs[i]) begin
            drive(vecs[i].rs, vecs[i].rd, vecs[i].rf, vecs[i].tk);
            repeat (vecs[i].cycles) @(posedge clk);
            #1;
            check(vecs[i].name, pack_act(),
                  pack_exp(vecs[i].gs, vecs[i].gd, vecs[i].inl, vecs[i].lvl));
        end

        // Asynchronous reset mid-grant: outputs must clear with no clock edge in between.
        #2 rst_n = 1'b0;
        #1 check("async_reset", pack_act(), pack_exp(0, 0, 0, 3'd0));
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_reset_grant", pack_act(), pack_exp(1, 0, 0, 3'd0));

        drive(0, 0, 0, 0);
        @(posedge clk);
        #1 check("final_idle", pack_act(), pack_exp(0, 0, 0, 3'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
